matrix_scan_debounce: RTL and testbench

//  Parametrised keyboard-matrix scanner. It drives active-low rows and samples

---
 rtl/matrix_scan_debounce_if.sv | 13 +
 rtl/matrix_scan_debounce.sv | 154 +++++++++++++++
 tb/tb_matrix_scan_debounce.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_debounce_if.sv
// Key-event stream from the matrix scanner: a first-word-fall-through head
// with a ready/valid handshake.
interface matrix_scan_debounce_if #(
    parameter int KW = 7
);
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_code;
    logic          evt_press;

    modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);
endinterface

// File: rtl/matrix_scan_debounce.sv
// Keyboard matrix scanner. Drives active-low rows, debounces each key on its own
// counter, and queues press/release events in a small FWFT FIFO.
module matrix_scan_debounce #(
    parameter int ROWS     = 6,
    parameter int COLS     = 21,
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 8,
    localparam int KEYS    = ROWS * COLS,
    localparam int KW      = $clog2(KEYS)
) (
    input  logic                   clk_scan,
    input  logic                   reset,
    input  logic                   enabled,
    input  logic [COLS-1:0]        col,
    output logic [ROWS-1:0]        row_n,
    output logic [KEYS-1:0]        key_state,
    output logic                   frame_sync,
    output logic                   evt_drop,
    matrix_scan_debounce_if.master evt
);

    localparam int DW   = $clog2(DWELL);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW   = $clog2(DEBOUNCE + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [COLS-1:0] col_m_q, col_s_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KEYS-1:0] key_state_q, key_state_d;
    logic [CW-1:0]   cnt_q [KEYS];
    logic [CW-1:0]   cnt_d [KEYS];
    logic [KW:0]     mem_q [DEPTH];
    logic [KW:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            drop_q, drop_d;

    logic            sample;
    logic            full;
    logic            pop;
    logic            push;
    logic [KW-1:0]   push_code;
    logic            push_press;
    logic            blocked;
    logic            found;
    logic [KW-1:0]   k_idx;

    assign sample     = enabled && (dwell_q == DW'(DWELL - 1));
    assign full       = (count_q == CNTW'(DEPTH));
    assign pop        = evt.evt_valid && evt.evt_ready;
    assign row_n      = enabled ? ~(ROWS'(1) << row_q) : '1;
    assign frame_sync = enabled && (row_q == '0) && (dwell_q == '0);
    assign key_state  = key_state_q;
    assign evt_drop   = drop_q;
    assign evt.evt_valid = (count_q != '0);
    assign {evt.evt_code, evt.evt_press} = mem_q[rd_q];

    always_comb begin
        dwell_d = dwell_q;
        row_d   = row_q;
        if (enabled) begin
            if (dwell_q == DW'(DWELL - 1)) begin
                dwell_d = '0;
                row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Only the lowest eligible column may flip per row sample; a blocked flip
    // leaves its counter saturated so it retries on the next frame.
    always_comb begin
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        push_code   = '0;
        push_press  = 1'b0;
        blocked     = 1'b0;
        found       = 1'b0;
        k_idx       = '0;
        if (sample) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                k_idx = KW'(int'(row_q) * COLS + int'(c));
                if (col_s_q[CIW'(c)] == key_state_q[k_idx]) begin
                    cnt_d[k_idx] = '0;
                end else if (!found && (int'(cnt_q[k_idx]) + 1 >= DEBOUNCE)) begin
                    found = 1'b1;
                    if (!full) begin
                        key_state_d[k_idx] = ~key_state_q[k_idx];
                        cnt_d[k_idx]       = '0;
                        push               = 1'b1;
                        push_code          = k_idx;
                        push_press         = ~key_state_q[k_idx];
                    end else begin
                        blocked      = 1'b1;
                        cnt_d[k_idx] = CW'(DEBOUNCE);
                    end
                end else begin
                    cnt_d[k_idx] = (int'(cnt_q[k_idx]) >= DEBOUNCE) ? cnt_q[k_idx]
                                                                    : cnt_q[k_idx] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CNTW'(push) - CNTW'(pop);
        drop_d  = drop_q | blocked;
        if (push) begin
            mem_d[wr_q] = {push_code, push_press};
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_scan or posedge reset) begin
        if (reset) begin
            col_m_q     <= '0;
            col_s_q     <= '0;
            dwell_q     <= '0;
            row_q       <= '0;
            key_state_q <= '0;
            cnt_q       <= '{default: '0};
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
        end else begin
            col_m_q     <= col;
            col_s_q     <= col_m_q;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan_debounce.sv
// Directed bench for matrix_scan_debounce: a key-matrix model drives col from
// row_n, and a scoreboard queue holds the events each stimulus step should produce.
module tb_matrix_scan_debounce;

    localparam int ROWS = 6;
    localparam int COLS = 21;
    localparam int KEYS = ROWS * COLS;
    localparam int KW   = $clog2(KEYS);

    logic            clk_scan = 1'b0;
    logic            reset;
    logic            enabled;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row_n;
    logic [KEYS-1:0] key_state;
    logic            frame_sync;
    logic            evt_drop;
    logic [KEYS-1:0] pressed;
    logic [KEYS-1:0] ks_saved;

    logic [KW:0] exp_q [$];
    logic [KW:0] exp_e;
    int checks = 0;
    int errors = 0;
    int n;

    matrix_scan_debounce_if #(.KW(KW)) evt_if ();

    matrix_scan_debounce #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(4), .DEBOUNCE(4), .DEPTH(8)
    ) dut (
        .clk_scan   (clk_scan),
        .reset      (reset),
        .enabled    (enabled),
        .col        (col),
        .row_n      (row_n),
        .key_state  (key_state),
        .frame_sync (frame_sync),
        .evt_drop   (evt_drop),
        .evt        (evt_if)
    );

    always #5 clk_scan = ~clk_scan;

    // Pressed switch connects a driven (low) row to its column.
    always_comb begin
        col = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS + c] && !row_n[r]) col[c] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(input int frames);
        for (int f = 0; f < frames; f++) begin
            int t = 0;
            do begin
                @(negedge clk_scan);
                t++;
            end while (!frame_sync && t < 200);
            chk("frame_sync_seen", 32'(frame_sync), 1);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_scan);
        #1 evt_if.evt_ready = v;
    endtask

    task automatic expect_evt(input int code, input logic press);
        exp_q.push_back({KW'(code), press});
    endtask

    always @(negedge clk_scan) begin
        if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
            chk("evt_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                chk("evt_code", 32'(evt_if.evt_code), 32'(exp_e[KW:1]));
                chk("evt_press", 32'(evt_if.evt_press), 32'(exp_e[0]));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        enabled = 1'b1;
        pressed = '0;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(negedge clk_scan);
        chk("rst_evt_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_key_state", 32'(key_state == '0), 1);
        chk("rst_row_n", 32'(row_n), 32'(6'b111110));
        chk("rst_evt_drop", 32'(evt_drop), 0);
        reset = 1'b0;

        // single key 47 (row 2, col 5): press then release
        wait_fs(1);
        chk("row0_drive", 32'(row_n), 32'(6'b111110));
        pressed[47] = 1'b1;
        expect_evt(47, 1'b1);
        wait_fs(3);
        chk("t1_press_early", 32'(key_state[47]), 0);
        wait_fs(1);
        chk("t1_press", 32'(key_state[47]), 1);
        pressed[47] = 1'b0;
        expect_evt(47, 1'b0);
        wait_fs(3);
        chk("t1_rel_early", 32'(key_state[47]), 1);
        wait_fs(1);
        chk("t1_rel", 32'(key_state[47]), 0);

        // bounce every frame, then settle pressed
        for (int i = 0; i < 10; i++) begin
            pressed[47] = (i % 2 == 0);
            wait_fs(1);
        end
        chk("t2_bounce_state", 32'(key_state[47]), 0);
        pressed[47] = 1'b1;
        expect_evt(47, 1'b1);
        wait_fs(3);
        chk("t2_settle_early", 32'(key_state[47]), 0);
        wait_fs(1);
        chk("t2_settle", 32'(key_state[47]), 1);
        pressed[47] = 1'b0;
        expect_evt(47, 1'b0);
        wait_fs(5);

        // two keys in one row flip on consecutive frames
        pressed[3] = 1'b1;
        pressed[7] = 1'b1;
        expect_evt(3, 1'b1);
        expect_evt(7, 1'b1);
        wait_fs(4);
        chk("t3_key3_first", 32'(key_state[3]), 1);
        chk("t3_key7_wait", 32'(key_state[7]), 0);
        wait_fs(1);
        chk("t3_key7_next", 32'(key_state[7]), 1);
        pressed[3] = 1'b0;
        pressed[7] = 1'b0;
        expect_evt(3, 1'b0);
        expect_evt(7, 1'b0);
        wait_fs(6);

        // FIFO full: nine presses, the ninth is deferred until space frees
        set_ready(1'b0);
        wait_fs(1);
        for (int k = 0; k < 9; k++) begin
            pressed[k] = 1'b1;
            expect_evt(k, 1'b1);
        end
        wait_fs(11);
        chk("t4_drop_before", 32'(evt_drop), 0);
        chk("t4_key7", 32'(key_state[7]), 1);
        wait_fs(1);
        chk("t4_drop", 32'(evt_drop), 1);
        chk("t4_key8_held", 32'(key_state[8]), 0);
        chk("t4_valid", 32'(evt_if.evt_valid), 1);
        chk("t4_head_stable", 32'(evt_if.evt_code), 0);
        set_ready(1'b1);
        wait_fs(2);
        chk("t4_key8_late", 32'(key_state[8]), 1);
        for (int k = 0; k < 9; k++) begin
            pressed[k] = 1'b0;
            expect_evt(k, 1'b0);
        end
        wait_fs(14);
        chk("t4_drop_sticky", 32'(evt_drop), 1);

        // disable mid row 3, then resume at the held position
        pressed[47] = 1'b1;
        expect_evt(47, 1'b1);
        wait_fs(5);
        chk("t5_pre_press", 32'(key_state[47]), 1);
        repeat (13) @(negedge clk_scan);
        enabled  = 1'b0;
        ks_saved = key_state;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_scan);
            chk("t5_rows_off", 32'(row_n), 32'(6'b111111));
            chk("t5_no_sync", 32'(frame_sync), 0);
        end
        chk("t5_ks_frozen", 32'(key_state === ks_saved), 1);
        enabled = 1'b1;
        #1 chk("t5_resume_row", 32'(row_n), 32'(6'b110111));
        n = 0;
        do begin
            @(negedge clk_scan);
            n++;
        end while (!frame_sync && n < 50);
        chk("t5_cycles_to_sync", 32'(n), 11);
        pressed[47] = 1'b0;
        expect_evt(47, 1'b0);
        wait_fs(6);

        // reset mid-frame with four events queued
        set_ready(1'b0);
        wait_fs(1);
        for (int k = 0; k < 4; k++) pressed[k] = 1'b1;
        wait_fs(7);
        chk("t6_valid_before", 32'(evt_if.evt_valid), 1);
        chk("t6_ks_before", 32'(key_state[3:0]), 32'hF);
        repeat (13) @(negedge clk_scan);
        chk("t6_row3", 32'(row_n), 32'(6'b110111));
        reset   = 1'b1;
        pressed = '0;
        @(negedge clk_scan);
        chk("t6_evt_valid", 32'(evt_if.evt_valid), 0);
        chk("t6_key_state", 32'(key_state == '0), 1);
        chk("t6_row_n", 32'(row_n), 32'(6'b111110));
        chk("t6_evt_drop", 32'(evt_drop), 0);
        reset = 1'b0;
        set_ready(1'b1);
        wait_fs(6);
        chk("t6_quiet", 32'(evt_if.evt_valid), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
